// File: rtl/reg_file_wb_pkg.sv
// rtl/reg_file_wb_pkg.sv - shared widths, flag struct and flag reset value for the register file
package reg_file_wb_pkg;

    localparam int REG_W = 8;
    localparam int REG_D = 3;

    typedef struct packed {
        logic zero;
        logic parity;
        logic odd;
    } flags_t;

    // Flags as they would be derived from an all-zero value
    localparam flags_t FLAGS_RST = '{zero: 1'b1, parity: 1'b0, odd: 1'b0};

endpackage

// File: rtl/reg_file_wb_if.sv
// rtl/reg_file_wb_if.sv - write/read/flag bus between the ALU datapath and the register file
interface reg_file_wb_if import reg_file_wb_pkg::*; #(
    parameter int W = REG_W,
    parameter int D = REG_D
) ();

    logic         WriteEn;
    logic [D-1:0] Waddr;
    logic [W-1:0] DataIn;
    logic         FlagEn;
    logic [D-1:0] RaddrA;
    logic [D-1:0] RaddrB;
    logic [W-1:0] DataOutA;
    logic [W-1:0] DataOutB;
    logic         Zero;
    logic         Parity;
    logic         Odd;

    modport master (
        output WriteEn, Waddr, DataIn, FlagEn, RaddrA, RaddrB,
        input  DataOutA, DataOutB, Zero, Parity, Odd
    );

    modport slave (
        input  WriteEn, Waddr, DataIn, FlagEn, RaddrA, RaddrB,
        output DataOutA, DataOutB, Zero, Parity, Odd
    );

endinterface

// File: rtl/reg_file_wb_status_flags.sv
// rtl/reg_file_wb_status_flags.sv - registered Zero/Parity/Odd status derived from a written value
module status_flags import reg_file_wb_pkg::*; #(
    parameter int W = REG_W
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Update,
    input  logic [W-1:0] Value,
    output flags_t       Flags
);

    flags_t r_flags;

    // Capture flags of the value being written; reset to the zero-value flags
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_flags <= FLAGS_RST;
        end else if (Update) begin
            r_flags.zero   <= (Value == '0);
            r_flags.parity <= ^Value;
            r_flags.odd    <= Value[0];
        end
    end

    assign Flags = r_flags;

endmodule

// File: rtl/reg_file_wb.sv
// rtl/reg_file_wb.sv - 2**D x W register file with two bypassed async read ports and write-back flags
module reg_file_wb import reg_file_wb_pkg::*; #(
    parameter int W = REG_W,
    parameter int D = REG_D
) (
    input  logic          Clk,
    input  logic          Reset,
    reg_file_wb_if.slave  bus
);

    localparam int NREG = 1 << D;

    logic [W-1:0] r_regs [NREG];

    logic         w_bypass_a;
    logic         w_bypass_b;
    logic [W-1:0] w_dout_a;
    logic [W-1:0] w_dout_b;
    logic         w_flag_update;
    flags_t       w_flags;

    // Storage: cleared asynchronously by reset, one write per rising edge otherwise
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.WriteEn) begin
            r_regs[bus.Waddr] <= bus.DataIn;
        end
    end

    // A write held off by reset must not leak through the bypass either
    assign w_bypass_a = Reset && bus.WriteEn && (bus.RaddrA == bus.Waddr);
    assign w_bypass_b = Reset && bus.WriteEn && (bus.RaddrB == bus.Waddr);

    // Read ports: same-cycle write data wins over the stored value
    always_comb begin
        w_dout_a = r_regs[bus.RaddrA];
        w_dout_b = r_regs[bus.RaddrB];
        if (w_bypass_a) begin
            w_dout_a = bus.DataIn;
        end
        if (w_bypass_b) begin
            w_dout_b = bus.DataIn;
        end
    end

    assign bus.DataOutA = w_dout_a;
    assign bus.DataOutB = w_dout_b;

    assign w_flag_update = bus.WriteEn && bus.FlagEn;

    status_flags #(.W(W)) u_status_flags (
        .Clk    (Clk),
        .Reset  (Reset),
        .Update (w_flag_update),
        .Value  (bus.DataIn),
        .Flags  (w_flags)
    );

    assign bus.Zero   = w_flags.zero;
    assign bus.Parity = w_flags.parity;
    assign bus.Odd    = w_flags.odd;

endmodule

// File: tb/tb_reg_file_wb.sv
// tb/tb_reg_file_wb.sv - directed and randomized checks of reg_file_wb against a reference model
module tb_reg_file_wb;
    import reg_file_wb_pkg::*;

    localparam int W = REG_W;
    localparam int D = REG_D;
    localparam int N = 1 << D;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    reg_file_wb_if #(.W(W), .D(D)) bus ();

    reg_file_wb #(.W(W), .D(D)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    logic [W-1:0] m_regs [N];
    logic         m_zero;
    logic         m_par;
    logic         m_odd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [D-1:0] wa, input logic [W-1:0] din,
                         input logic fe, input logic [D-1:0] ra, input logic [D-1:0] rb);
        bus.WriteEn = we;
        bus.Waddr   = wa;
        bus.DataIn  = din;
        bus.FlagEn  = fe;
        bus.RaddrA  = ra;
        bus.RaddrB  = rb;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_zero = 1'b1;
        m_par  = 1'b0;
        m_odd  = 1'b0;
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [D-1:0] ra);
        if (Reset && bus.WriteEn && ra == bus.Waddr) return bus.DataIn;
        return m_regs[ra];
    endfunction

    task automatic check_reads(input string tag);
        chk({tag, "_A"}, bus.DataOutA, exp_rd(bus.RaddrA));
        chk({tag, "_B"}, bus.DataOutB, exp_rd(bus.RaddrB));
    endtask

    task automatic check_flags(input string tag);
        chk({tag, "_zero"},   W'(bus.Zero),   W'(m_zero));
        chk({tag, "_parity"}, W'(bus.Parity), W'(m_par));
        chk({tag, "_odd"},    W'(bus.Odd),    W'(m_odd));
    endtask

    task automatic check_flags_const(input string tag, input logic z, input logic p, input logic o);
        chk({tag, "_zero"},   W'(bus.Zero),   W'(z));
        chk({tag, "_parity"}, W'(bus.Parity), W'(p));
        chk({tag, "_odd"},    W'(bus.Odd),    W'(o));
    endtask

    // One rising edge: advance the model from the inputs present at the edge, then check flags
    task automatic tick(input string tag);
        @(posedge Clk);
        if (Reset && bus.WriteEn) begin
            m_regs[bus.Waddr] = bus.DataIn;
            if (bus.FlagEn) begin
                m_zero = (bus.DataIn == '0);
                m_par  = ($countones(bus.DataIn) % 2) == 1;
                m_odd  = (bus.DataIn % 2) == 1;
            end
        end
        #1;
        check_flags(tag);
    endtask

    initial begin
        model_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // Reset state
        #12;
        chk("rst_A", bus.DataOutA, 8'h00);
        chk("rst_B", bus.DataOutB, 8'h00);
        check_flags_const("rst", 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;

        // Write/read without flags
        drive(1'b1, 3'd1, 8'h3C, 1'b0, 3'd0, 3'd0);
        tick("wr1");
        drive(1'b1, 3'd2, 8'hC5, 1'b0, 3'd0, 3'd0);
        tick("wr2");
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd2);
        #1;
        chk("wr_A", bus.DataOutA, 8'h3C);
        chk("wr_B", bus.DataOutB, 8'hC5);
        check_flags_const("wr_flags", 1'b1, 1'b0, 1'b0);

        // Bypass on both ports
        drive(1'b1, 3'd4, 8'h11, 1'b0, 3'd0, 3'd0);
        tick("byp_pre");
        drive(1'b1, 3'd4, 8'h77, 1'b0, 3'd4, 3'd4);
        #1;
        chk("byp_A", bus.DataOutA, 8'h77);
        chk("byp_B", bus.DataOutB, 8'h77);
        tick("byp_edge");
        drive(1'b0, 3'd4, 8'h00, 1'b0, 3'd4, 3'd4);
        #1;
        chk("byp_post_A", bus.DataOutA, 8'h77);
        chk("byp_post_B", bus.DataOutB, 8'h77);

        // Flag updates
        drive(1'b1, 3'd6, 8'h07, 1'b1, 3'd6, 3'd0);
        tick("flg07");
        check_flags_const("flg07c", 1'b0, 1'b1, 1'b1);
        drive(1'b1, 3'd6, 8'h00, 1'b1, 3'd6, 3'd0);
        tick("flg00");
        check_flags_const("flg00c", 1'b1, 1'b0, 1'b0);

        // Flag hold
        drive(1'b1, 3'd7, 8'h07, 1'b1, 3'd0, 3'd0);
        tick("hold_set");
        drive(1'b0, 3'd0, 8'hFF, 1'b1, 3'd0, 3'd0);
        tick("hold1");
        check_flags_const("hold1c", 1'b0, 1'b1, 1'b1);
        chk("hold1_R0", bus.DataOutA, 8'h00);
        drive(1'b1, 3'd0, 8'h02, 1'b0, 3'd1, 3'd1);
        tick("hold2");
        check_flags_const("hold2c", 1'b0, 1'b1, 1'b1);
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0);
        #1;
        chk("hold2_R0", bus.DataOutA, 8'h02);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), D'($urandom_range(0, N - 1)), W'($urandom),
                  1'($urandom_range(0, 1)), D'($urandom_range(0, N - 1)), D'($urandom_range(0, N - 1)));
            #1;
            check_reads("rnd");
            tick("rnd");
        end

        // Asynchronous reset mid-cycle
        drive(1'b1, 3'd3, 8'h5A, 1'b1, 3'd3, 3'd3);
        tick("rst3_wr");
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd3);
        #1;
        chk("rst3_pre", bus.DataOutA, 8'h5A);
        #1;
        Reset = 1'b0;
        model_reset();
        #1;
        chk("async_A", bus.DataOutA, 8'h00);
        chk("async_B", bus.DataOutB, 8'h00);
        check_flags_const("async", 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;

        // Write colliding with reset is dropped, flags stay at reset values
        drive(1'b1, 3'd5, 8'h07, 1'b1, 3'd0, 3'd0);
        tick("col_pre");
        drive(1'b1, 3'd5, 8'hAA, 1'b1, 3'd5, 3'd5);
        Reset = 1'b0;
        model_reset();
        tick("col_edge");
        drive(1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd5);
        Reset = 1'b1;
        #1;
        chk("col_A", bus.DataOutA, 8'h00);
        chk("col_B", bus.DataOutB, 8'h00);
        check_flags_const("col", 1'b1, 1'b0, 1'b0);
        tick("col_after");
        check_reads("col_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
